// File: rtl/jtag_debug_cmd_queue.sv
// Sysclk-side JTAG debug command receiver: syncs update strobes, queues {IR,DR}.
// Optional one-hot action pulses on pop when DBG_CMD_PULSE_EN is defined.
module jtag_debug_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 35
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DR_W-1:0]      sr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [DR_W-1:0]      cmd_data,
  output logic                 cmd_act,
  output logic                 ack_toggle,
  input  logic                 clr_ovf,
  output logic                 overflow,
  output logic [7:0]           drop_cnt,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = IR_W + DR_W;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_edge_q, uir_edge_q;
  logic [IR_W-1:0]        ir_reg_q, ir_reg_d;
  logic                   push_q;
  logic [EW-1:0]          push_data_q, push_data_d;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [EW-1:0]          mem_d [DEPTH];
  logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
  logic [EW-1:0]          head_q, head_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             drop_q, drop_d;
  logic                   udr_rise, uir_rise;
  logic                   pop, full, wr_en, drop;

  assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
  assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;

  always_comb begin
    ir_reg_d    = uir_rise ? ir_in : ir_reg_q;
    push_data_d = {ir_reg_d, sr};
    pop   = valid_q & cmd_ready;
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);
    wr_en = push_q & (~full | pop);
    drop  = push_q & full & ~pop;
    wr_d  = wr_q + (AW+1)'(wr_en);
    rd_d  = rd_q + (AW+1)'(pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = push_data_q;
    // head tracks the post-update read slot, so a push into empty shows next cycle
    head_d  = mem_d[rd_d[AW-1:0]];
    valid_d = (wr_d != rd_d);
    ack_d   = ack_q ^ wr_en;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q  <= '0;
      uir_sync_q  <= '0;
      udr_edge_q  <= 1'b0;
      uir_edge_q  <= 1'b0;
      ir_reg_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_edge_q  <= udr_sync_q[SYNC_STAGES-1];
      uir_edge_q  <= uir_sync_q[SYNC_STAGES-1];
      ir_reg_q    <= ir_reg_d;
      push_q      <= udr_rise;
      push_data_q <= push_data_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign cmd_valid  = valid_q;
  assign cmd_ir     = head_q[EW-1:DR_W];
  assign cmd_data   = head_q[DR_W-1:0];
  assign cmd_act    = cmd_data[ACT_BIT];
  assign ack_toggle = ack_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;

`ifdef DBG_CMD_PULSE_EN
  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      take_action[cmd_ir]    = cmd_act;
      take_no_action[cmd_ir] = ~cmd_act;
    end
  end
`else
  assign take_action    = '0;
  assign take_no_action = '0;
`endif

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Directed bench for jtag_debug_cmd_queue: latency, ordering, overflow, pulses.
// Pulse expectations follow DBG_CMD_PULSE_EN as the DUT is built.
module tb_jtag_debug_cmd_queue;

`ifdef DBG_CMD_PULSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_udr, vs_uir;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        cmd_act, ack_toggle, clr_ovf, overflow;
  logic [7:0]  drop_cnt;
  logic [3:0]  take_action, take_no_action;

  int nvec = 0;
  int nerr = 0;

  logic [37:0] d [4];
  logic [37:0] e [5];

  always #5 clk = ~clk;

  jtag_debug_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .cmd_act(cmd_act), .ack_toggle(ack_toggle), .clr_ovf(clr_ovf),
    .overflow(overflow), .drop_cnt(drop_cnt),
    .take_action(take_action), .take_no_action(take_no_action)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic udr_pulse(input logic [37:0] v);
    @(negedge clk);
    sr = v;
    vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic uir_pulse(input logic [1:0] v);
    @(negedge clk);
    ir_in = v;
    vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0;
    sr = '0; ir_in = '0; cmd_ready = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 38'h8_0000_0A00 + 38'(i);
    for (int i = 0; i < 5; i++) e[i] = 38'h0_1111_0000 + 38'(i);

    // T1 reset
    repeat (3) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_data", {cmd_ir, cmd_data}, 0);
    chk("rst_act_ack", {cmd_act, ack_toggle}, 0);
    chk("rst_ovf_cnt", {overflow, drop_cnt}, 0);
    chk("rst_pulses", {take_action, take_no_action}, 0);
    vs_udr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold_valid", cmd_valid, 0);
    end

    // T2 single command, latency SYNC_STAGES+2
    uir_pulse(2'b10);
    cmd_ready = 1'b1;
    @(negedge clk);
    sr = 38'h8_0000_1234;
    vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_lat3", cmd_valid, 0);
    @(negedge clk);
    chk("t2_lat4", cmd_valid, 1);
    chk("t2_ir", cmd_ir, 2);
    chk("t2_data", cmd_data, 38'h8_0000_1234);
    chk("t2_act", cmd_act, 1);
    chk("t2_ta", take_action, PEN ? 4'b0100 : 4'b0000);
    chk("t2_tna", take_no_action, 0);
    @(negedge clk);
    chk("t2_popped", cmd_valid, 0);
    chk("t2_ta_off", take_action, 0);
    chk("t2_ack", ack_toggle, 1);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);

    // T3 backpressure, overflow, ordered drain
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      udr_pulse(d[i]);
      chk("t3_ack", ack_toggle, (i % 2 == 0) ? 0 : 1);
    end
    chk("t3_full_valid", cmd_valid, 1);
    chk("t3_head_held", cmd_data, d[0]);
    chk("t3_no_ovf", overflow, 0);
    udr_pulse(38'h3F_FFFF_FFFF);
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_ack_drop", ack_toggle, 1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", {cmd_valid, cmd_ir, cmd_data}, {1'b1, 2'b10, d[i]});
      @(negedge clk);
    end
    chk("t3_empty", cmd_valid, 0);
    cmd_ready = 1'b0;

    // T4 full with simultaneous pop
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t4_clr", {overflow, drop_cnt}, 0);
    uir_pulse(2'b01);
    for (int i = 0; i < 4; i++) udr_pulse(e[i]);
    chk("t4_ack_full", ack_toggle, 1);
    @(negedge clk);
    sr = e[4];
    vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("t4_no_drop", {overflow, drop_cnt}, 0);
    chk("t4_ack_flip", ack_toggle, 0);
    chk("t4_head", cmd_data, e[1]);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("t4_order", {cmd_valid, cmd_ir, cmd_data}, {1'b1, 2'b01, e[i]});
      if (i == 1) begin
        // T6 no-action pulse
        chk("t6_act0", cmd_act, 0);
        chk("t6_tna", take_no_action, PEN ? 4'b0010 : 4'b0000);
        chk("t6_ta", take_action, 0);
      end
      @(negedge clk);
    end
    chk("t4_empty", cmd_valid, 0);
    cmd_ready = 1'b0;

    // T5 saturation and clr_ovf priority
    for (int i = 0; i < 4; i++) udr_pulse(d[i]);
    for (int i = 0; i < 255; i++) udr_pulse(e[0]);
    chk("t5_sat", drop_cnt, 255);
    chk("t5_ovf", overflow, 1);
    udr_pulse(e[0]);
    chk("t5_sat_hold", drop_cnt, 255);
    @(negedge clk);
    vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t5_clr_drop", {overflow, drop_cnt}, 0);
    chk("t5_ack", ack_toggle, 0);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_order", cmd_data, d[i]);
      @(negedge clk);
    end
    chk("t5_empty", cmd_valid, 0);
    cmd_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
